uart_rx_param: RTL and testbench

Parametrised, synthesizable UART receiver. It generalises the fixed-format testbench UART monitor in data width, parity mode, stop-bit count and buffering, and adds framing, parity and overflow reporting. It sits either on the SoC `uart_tx` pin in the Didactic testbench as a self-checking monitor, or behind the SoC peripheral bus as a receive channel. Received frames go into a FIFO read through a valid/ready port.

---
 rtl/uart_rx_param_if.sv | 27 ++
 rtl/uart_rx_param.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Read port of the uart_rx_param receive FIFO.
// The receiver drives a registered head entry with valid/ready flow control.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_parity_err;
    logic                 rd_frame_err;
    logic                 rd_valid;
    logic                 rd_ready;

    modport master (
        output rd_data,
        output rd_parity_err,
        output rd_frame_err,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_parity_err,
        input  rd_frame_err,
        input  rd_valid,
        output rd_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronizer, mid-bit sampling FSM with parity and stop checks,
// and a receive FIFO with overflow reporting.
module uart_rx_param #(
    parameter int CLK_FREQ_HZ = 8000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic                             rx_en,
    input  logic                             rx,
    uart_rx_param_if.master                  rd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             overflow,
    input  logic                             clr_overflow,
    output logic                             word_done,
    output logic                             busy
);
    localparam int DIV     = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W   = $clog2(DIV);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = 1'(PARITY_ODD);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);

    generate
        if (DIV < 4) begin : g_bad_div
            $error("uart_rx_param: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx_param: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_rx_param: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Third flop keeps the previous synchronized level so a 1->0 edge can be seen.
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic start_edge;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_next;
    logic                 stop_idx;
    logic                 stop_idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 parity_err;
    logic                 parity_err_next;
    logic                 frame_err;
    logic                 frame_err_next;
    logic                 tick;
    logic                 commit;

    assign tick = (bit_cnt == '0);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_reg  <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            bit_idx    <= bit_idx_next;
            stop_idx   <= stop_idx_next;
            shift_reg  <= shift_next;
            parity_err <= parity_err_next;
            frame_err  <= frame_err_next;
        end
    end

    // Disabling the receiver outranks everything, including the final stop sample.
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        bit_idx_next    = bit_idx;
        stop_idx_next   = stop_idx;
        shift_next      = shift_reg;
        parity_err_next = parity_err;
        frame_err_next  = frame_err;
        commit          = 1'b0;

        if (state != IDLE && !rx_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_en && start_edge) begin
                        state_next   = START;
                        bit_cnt_next = CNT_HALF;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_sync) begin
                            state_next = IDLE;
                        end else begin
                            state_next      = DATA;
                            bit_cnt_next    = CNT_FULL;
                            bit_idx_next    = '0;
                            parity_err_next = 1'b0;
                            frame_err_next  = 1'b0;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_next   = {rx_sync, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_next = CNT_FULL;
                        bit_idx_next = bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state_next    = (PARITY_EN != 0) ? PARITY : STOP;
                            stop_idx_next = 1'b0;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (tick) begin
                        parity_err_next = (^shift_reg) ^ rx_sync ^ PAR_ODD;
                        state_next      = STOP;
                        bit_cnt_next    = CNT_FULL;
                        stop_idx_next   = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        frame_err_next = frame_err | ~rx_sync;
                        bit_cnt_next   = CNT_FULL;
                        if (stop_idx == STOP_LAST) begin
                            commit     = 1'b1;
                            state_next = IDLE;
                        end else begin
                            stop_idx_next = stop_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt - 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] new_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_inc;
    logic [LVL_W-1:0]   count;
    logic               pop;
    logic               push;

    assign new_entry  = {shift_reg, parity_err, frame_err_next};
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign pop        = (count != '0) && rd.rd_ready;
    assign push       = commit && ((count != LVL_FULL) || pop);

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // The head register is loaded from the array on a pop, or straight from the
    // committed frame when it is about to become the only entry.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head      <= '0;
            overflow  <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= commit;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (pop && (count > LVL_ONE)) begin
                head <= mem[rd_ptr_inc];
            end else if (push && ((count == '0) || (pop && (count == LVL_ONE)))) begin
                head <= new_entry;
            end
            if (clr_overflow) begin
                overflow <= 1'b0;
            end else if (commit && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign rd.rd_data       = head[ENTRY_W-1:2];
    assign rd.rd_parity_err = head[1];
    assign rd.rd_frame_err  = head[0];
    assign rd.rd_valid      = (count != '0);
    assign level            = count;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8N1 receiver and an 8E2 receiver driven with
// directed and random frames, scored against a queue model of what was sent.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int DIV   = 8000000 / 115200;
    localparam int DEPTH = 4;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       rx_en  = 1'b1;
    logic       rx_a   = 1'b1;
    logic       rx_b   = 1'b1;
    logic       clr_ovf_a = 1'b0;
    logic       clr_ovf_b = 1'b0;
    logic [2:0] level_a;
    logic [2:0] level_b;
    logic       ovf_a, ovf_b;
    logic       wd_a, wd_b;
    logic       busy_a, busy_b;

    uart_rx_param_if #(.DATA_BITS(8)) rd_a ();
    uart_rx_param_if #(.DATA_BITS(8)) rd_b ();

    uart_rx_param #(
        .CLK_FREQ_HZ(8000000), .BAUD_RATE(115200), .DATA_BITS(8),
        .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clk_in(clk_in), .reset(reset), .rx_en(rx_en), .rx(rx_a), .rd(rd_a.master),
        .level(level_a), .overflow(ovf_a), .clr_overflow(clr_ovf_a),
        .word_done(wd_a), .busy(busy_a)
    );

    uart_rx_param #(
        .CLK_FREQ_HZ(8000000), .BAUD_RATE(115200), .DATA_BITS(8),
        .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk_in(clk_in), .reset(reset), .rx_en(rx_en), .rx(rx_b), .rd(rd_b.master),
        .level(level_b), .overflow(ovf_b), .clr_overflow(clr_ovf_b),
        .word_done(wd_b), .busy(busy_b)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int wd_cnt_a = 0;
    int wd_cnt_b = 0;
    int busy_cnt_a = 0;

    always @(negedge clk_in) begin
        if (wd_a) wd_cnt_a++;
        if (wd_b) wd_cnt_b++;
        if (busy_a) busy_cnt_a++;
    end

    // Expected FIFO contents per receiver, each entry {data, parity_err, frame_err}.
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    logic       m_ovf_a = 1'b0;
    logic       m_ovf_b = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) rx_a = b; else rx_b = b;
        repeat (DIV) @(negedge clk_in);
    endtask

    task automatic drive_frame(input int which, input logic [7:0] data, input logic par_bit,
                               input logic s0, input logic s1);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
        if (which == 1) drive_bit(which, par_bit);
        drive_bit(which, s0);
        if (which == 1) drive_bit(which, s1);
        if (which == 0) rx_a = 1'b1; else rx_b = 1'b1;
        repeat (2 * DIV) @(negedge clk_in);
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] data, input logic par_bit,
                                 input logic s0, input logic s1);
        int   wd_before;
        int   wd_after;
        logic perr;
        logic ferr;
        wd_before = (which == 0) ? wd_cnt_a : wd_cnt_b;
        drive_frame(which, data, par_bit, s0, s1);
        perr = (which == 1) ? ((^data) ^ par_bit) : 1'b0;
        ferr = !s0 || ((which == 1) && !s1);
        if (which == 0) begin
            if (q_a.size() < DEPTH) q_a.push_back({data, perr, ferr}); else m_ovf_a = 1'b1;
        end else begin
            if (q_b.size() < DEPTH) q_b.push_back({data, perr, ferr}); else m_ovf_b = 1'b1;
        end
        wd_after = (which == 0) ? wd_cnt_a : wd_cnt_b;
        checkOutput("word_done_count", wd_after - wd_before, 1);
    endtask

    task automatic pop_check(input int which);
        logic [9:0] got;
        logic [9:0] exp;
        logic       valid;
        int         depth;
        @(negedge clk_in);
        if (which == 0) begin
            got = {rd_a.rd_data, rd_a.rd_parity_err, rd_a.rd_frame_err};
            valid = rd_a.rd_valid;
            depth = q_a.size();
        end else begin
            got = {rd_b.rd_data, rd_b.rd_parity_err, rd_b.rd_frame_err};
            valid = rd_b.rd_valid;
            depth = q_b.size();
        end
        if (depth == 0) begin
            checkOutput("pop_valid_empty", valid, 0);
        end else begin
            if (which == 0) exp = q_a.pop_front(); else exp = q_b.pop_front();
            checkOutput("pop_valid", valid, 1);
            checkOutput("pop_entry", got, exp);
            if (which == 0) rd_a.rd_ready = 1'b1; else rd_b.rd_ready = 1'b1;
            @(negedge clk_in);
            rd_a.rd_ready = 1'b0;
            rd_b.rd_ready = 1'b0;
        end
    endtask

    task automatic check_status(input int which);
        if (which == 0) begin
            checkOutput("level_a", level_a, q_a.size());
            checkOutput("overflow_a", ovf_a, m_ovf_a);
        end else begin
            checkOutput("level_b", level_b, q_b.size());
            checkOutput("overflow_b", ovf_b, m_ovf_b);
        end
    endtask

    task automatic drain(input int which);
        int n;
        n = (which == 0) ? q_a.size() : q_b.size();
        for (int i = 0; i < n; i++) pop_check(which);
        @(negedge clk_in);
        checkOutput("drained_valid", (which == 0) ? rd_a.rd_valid : rd_b.rd_valid, 0);
    endtask

    task automatic clear_overflow(input int which);
        @(negedge clk_in);
        if (which == 0) clr_ovf_a = 1'b1; else clr_ovf_b = 1'b1;
        @(negedge clk_in);
        clr_ovf_a = 1'b0;
        clr_ovf_b = 1'b0;
        if (which == 0) m_ovf_a = 1'b0; else m_ovf_b = 1'b0;
        @(negedge clk_in);
        check_status(which);
    endtask

    initial begin
        int         wd0;
        int         busy0;
        int         n;
        logic [7:0] d;
        logic       s0;
        logic       s1;

        rd_a.rd_ready = 1'b0;
        rd_b.rd_ready = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("rst_valid", rd_a.rd_valid, 0);
        checkOutput("rst_data", rd_a.rd_data, 0);
        checkOutput("rst_level", level_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_overflow", ovf_a, 0);
        checkOutput("rst_word_done", wd_a, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk_in);

        applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        checkOutput("a5_data", rd_a.rd_data, 8'hA5);
        checkOutput("a5_perr", rd_a.rd_parity_err, 0);
        checkOutput("a5_ferr", rd_a.rd_frame_err, 0);
        checkOutput("a5_level", level_a, 1);
        drain(0);

        applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1);
        checkOutput("stop_low_data", rd_a.rd_data, 8'h55);
        checkOutput("stop_low_ferr", rd_a.rd_frame_err, 1);
        drain(0);

        wd0 = wd_cnt_a;
        busy0 = busy_cnt_a;
        rx_a = 1'b0;
        repeat (20) @(negedge clk_in);
        rx_a = 1'b1;
        repeat (3 * DIV) @(negedge clk_in);
        checkOutput("glitch_busy", (busy_cnt_a > busy0) ? 1 : 0, 1);
        checkOutput("glitch_word_done", wd_cnt_a - wd0, 0);
        checkOutput("glitch_level", level_a, 0);

        wd0 = wd_cnt_a;
        for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i), 1'b0, 1'b1, 1'b1);
        checkOutput("full_level", level_a, 4);
        checkOutput("full_overflow", ovf_a, 1);
        checkOutput("full_word_done", wd_cnt_a - wd0, 5);
        drain(0);
        clear_overflow(0);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                s0 = ($urandom_range(0, 3) != 0);
                applyStimulus(0, d, 1'b0, s0, 1'b1);
            end
            check_status(0);
            drain(0);
            if (m_ovf_a) clear_overflow(0);
        end

        applyStimulus(1, 8'h03, 1'b1, 1'b1, 1'b1);
        checkOutput("par_data", rd_b.rd_data, 8'h03);
        checkOutput("par_perr", rd_b.rd_parity_err, 1);
        checkOutput("par_ferr", rd_b.rd_frame_err, 0);
        drain(1);

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            s0 = ($urandom_range(0, 3) != 0);
            s1 = ($urandom_range(0, 3) != 0);
            applyStimulus(1, d, (^d) ^ ($urandom_range(0, 3) == 0), s0, s1);
            if ($urandom_range(0, 1) == 1) pop_check(1);
            check_status(1);
        end
        drain(1);
        if (m_ovf_b) clear_overflow(1);

        applyStimulus(0, 8'h7E, 1'b0, 1'b1, 1'b1);
        wd0 = wd_cnt_a;
        fork
            drive_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1);
            begin
                repeat (4 * DIV) @(negedge clk_in);
                reset = 1'b0;
                @(negedge clk_in);
                checkOutput("midrst_valid", rd_a.rd_valid, 0);
                checkOutput("midrst_level", level_a, 0);
                checkOutput("midrst_busy", busy_a, 0);
                checkOutput("midrst_data", rd_a.rd_data, 0);
                checkOutput("midrst_overflow", ovf_a, 0);
            end
        join
        reset = 1'b1;
        q_a.delete();
        q_b.delete();
        m_ovf_a = 1'b0;
        m_ovf_b = 1'b0;
        checkOutput("midrst_word_done", wd_cnt_a - wd0, 0);
        repeat (5) @(negedge clk_in);
        applyStimulus(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        checkOutput("after_rst_level", level_a, 1);
        checkOutput("after_rst_data", rd_a.rd_data, 8'h3C);
        drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
